// File: rtl/vit_symbol_sched_322.sv
// vit_symbol_sched_322: input-side symbol sequencer for the (3,2,2) backward-label Viterbi decoder.
// Latency: sym_out is registered and valid the cycle after le; seq_ready rises on the edge that completes the preload.
// Backpressure: in_ready drops on a registered-full FIFO, once N symbols are taken, or outside FILL/RUN.
// Optional feature macro: VIT_SCHED_BYPASS_EN (adds the bypass input for direct empty-FIFO loads).

// Small synchronous FIFO with occupancy count. A push on a full FIFO and a pop on an empty FIFO are ignored.
module vit_sched_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];

  // Storage write; contents are only ever read while count marks them as live, so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module vit_symbol_sched_322 #(
  parameter int NB      = 3,
  parameter int N       = 64,
  parameter int M       = 2,
  parameter int DEPTH   = 8,
  parameter int PRELOAD = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [NB-1:0] in_sym,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          le,
`ifdef VIT_SCHED_BYPASS_EN
  input  logic          bypass,
`endif
  output logic          seq_ready,
  output logic [NB-1:0] sym_out,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [8:0] N_LAST  = 9'(N);
  localparam logic [8:0] TOTAL   = 9'(N + M);
  localparam logic [AW+1:0] PRE_LVL = (AW+2)'(PRELOAD);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    FILL  = 5'b00010,
    RUN   = 5'b00100,
    FLUSH = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t        state;
  logic [8:0]    push_cnt;
  logic [8:0]    pop_cnt;
  logic [8:0]    push_cnt_nxt;
  logic [8:0]    pop_nxt;

  logic          fill_st;
  logic          run_st;
  logic          quota_open;
  logic          byp_take;
  logic          push_acc;
  logic          fifo_clear;
  logic          fifo_push;
  logic          fifo_pop;
  logic [NB-1:0] fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic [AW+1:0] occ_after;
  logic          fill_go;

  assign fill_st    = (state == FILL);
  assign run_st     = (state == RUN);
  assign quota_open = (push_cnt < N_LAST);

`ifdef VIT_SCHED_BYPASS_EN
  // An le that would otherwise be an erasure takes the arriving symbol straight to sym_out.
  assign byp_take = bypass & run_st & fifo_empty & le & in_valid & quota_open;
`else
  assign byp_take = 1'b0;
`endif

  // Full is the registered flag, so a same-cycle pop never opens room for a push.
  assign in_ready   = ((fill_st | run_st) & ~fifo_full & quota_open) | byp_take;
  assign push_acc   = in_valid & in_ready;
  assign fifo_push  = push_acc & ~byp_take;
  assign fifo_pop   = run_st & le & ~fifo_empty;
  assign fifo_clear = (state == IDLE) & start;

  assign push_cnt_nxt = push_cnt + 9'(push_acc);
  assign pop_nxt      = pop_cnt + 9'd1;

  // The preload test includes this cycle's push so seq_ready rises right after the qualifying push.
  assign occ_after = {1'b0, fifo_count} + (AW+2)'(fifo_push);
  assign fill_go   = (occ_after >= PRE_LVL) | (push_cnt_nxt == N_LAST);

  vit_sched_fifo #(
    .W     (NB),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (fifo_clear),
    .push     (fifo_push),
    .push_dat (in_sym),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  // Frame sequencing: state, symbol counters and every registered output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      push_cnt   <= '0;
      pop_cnt    <= '0;
      sym_out    <= '0;
      seq_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push_acc) begin
        push_cnt <= push_cnt_nxt;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            busy     <= 1'b1;
            push_cnt <= '0;
            pop_cnt  <= '0;
            sym_out  <= '0;
            underrun <= 1'b0;
          end
        end
        FILL: begin
          if (fill_go) begin
            state     <= RUN;
            seq_ready <= 1'b1;
          end
        end
        RUN: begin
          if (le) begin
            pop_cnt <= pop_nxt;
            if (!fifo_empty) begin
              sym_out <= fifo_head;
            end else if (byp_take) begin
              sym_out <= in_sym;
            end else begin
              // Starved decoder: feed an erasure and remember it for the frame.
              sym_out  <= '0;
              underrun <= 1'b1;
            end
            if (pop_nxt == N_LAST) begin
              if (M == 0) begin
                state      <= DONE;
                seq_ready  <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                state <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (le) begin
            sym_out <= '0;
            pop_cnt <= pop_nxt;
            if (pop_nxt == TOTAL) begin
              state      <= DONE;
              seq_ready  <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          seq_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vit_symbol_sched_322.sv
// tb_vit_symbol_sched_322: directed checks of the symbol sequencer across three parameter sets.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: in_ready is sampled before each edge to count accepted symbols.
module tb_vit_symbol_sched_322;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic       le;
  logic [2:0] in_sym;
  int         sel;

  int errors = 0;
  int checks = 0;

  logic       ir_a, sr_a, bz_a, fd_a, ur_a;
  logic       ir_b, sr_b, bz_b, fd_b, ur_b;
  logic       ir_c, sr_c, bz_c, fd_c, ur_c;
  logic [2:0] so_a, so_b, so_c;

  logic       in_ready, seq_ready, busy, frame_done, underrun;
  logic [2:0] sym_out;

  always #5 clock = ~clock;

  // A: short frame with full preload.
  vit_symbol_sched_322 #(.NB(3), .N(4), .M(2), .DEPTH(8), .PRELOAD(4)) u_a (
    .clock(clock), .reset(reset), .start(start & (sel == 0)), .in_sym(in_sym),
    .in_valid(in_valid & (sel == 0)), .in_ready(ir_a), .le(le & (sel == 0)),
`ifdef VIT_SCHED_BYPASS_EN
    .bypass(1'b0),
`endif
    .seq_ready(sr_a), .sym_out(so_a), .busy(bz_a), .frame_done(fd_a), .underrun(ur_a)
  );

  // B: frame longer than the FIFO, for full and underrun behaviour.
  vit_symbol_sched_322 #(.NB(3), .N(12), .M(2), .DEPTH(8), .PRELOAD(4)) u_b (
    .clock(clock), .reset(reset), .start(start & (sel == 1)), .in_sym(in_sym),
    .in_valid(in_valid & (sel == 1)), .in_ready(ir_b), .le(le & (sel == 1)),
`ifdef VIT_SCHED_BYPASS_EN
    .bypass(1'b0),
`endif
    .seq_ready(sr_b), .sym_out(so_b), .busy(bz_b), .frame_done(fd_b), .underrun(ur_b)
  );

  // C: frame shorter than the preload level.
  vit_symbol_sched_322 #(.NB(3), .N(2), .M(2), .DEPTH(8), .PRELOAD(4)) u_c (
    .clock(clock), .reset(reset), .start(start & (sel == 2)), .in_sym(in_sym),
    .in_valid(in_valid & (sel == 2)), .in_ready(ir_c), .le(le & (sel == 2)),
`ifdef VIT_SCHED_BYPASS_EN
    .bypass(1'b0),
`endif
    .seq_ready(sr_c), .sym_out(so_c), .busy(bz_c), .frame_done(fd_c), .underrun(ur_c)
  );

  // Route the selected instance's outputs to the common observation signals.
  always_comb begin
    in_ready = ir_c; seq_ready = sr_c; busy = bz_c; frame_done = fd_c; underrun = ur_c; sym_out = so_c;
    if (sel == 0) begin
      in_ready = ir_a; seq_ready = sr_a; busy = bz_a; frame_done = fd_a; underrun = ur_a; sym_out = so_a;
    end else if (sel == 1) begin
      in_ready = ir_b; seq_ready = sr_b; busy = bz_b; frame_done = fd_b; underrun = ur_b; sym_out = so_b;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   0);
    chk({tag, "_seq_ready"},  32'(seq_ready),  0);
    chk({tag, "_sym_out"},    32'(sym_out),    0);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_underrun"},   32'(underrun),   0);
  endtask

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] va [4];
  logic [2:0] vb [9];
  logic [2:0] vn [4];
  int acc;

  initial begin
    va = '{3'd5, 3'd3, 3'd7, 3'd1};
    vb = '{3'd1, 3'd4, 3'd7, 3'd2, 3'd5, 3'd0, 3'd3, 3'd6, 3'd1};
    vn = '{3'd2, 3'd4, 3'd6, 3'd0};
    sel = 0; reset = 1'b1; start = 1'b0; in_valid = 1'b0; le = 1'b0; in_sym = '0;
    tick(); tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick();

    // A: preload of 4 symbols, then 4 data and 2 tail loads.
    start = 1'b1; tick(); start = 1'b0;
    chk("a_busy", 32'(busy), 1);
    chk("a_fill_in_ready", 32'(in_ready), 1);
    chk("a_fill_seq_ready", 32'(seq_ready), 0);
    in_valid = 1'b1;
    in_sym = 3'd5; tick();
    in_sym = 3'd3; tick();
    in_sym = 3'd7; tick();
    chk("a_3push_seq_ready", 32'(seq_ready), 0);
    in_sym = 3'd1; tick();
    chk("a_4push_seq_ready", 32'(seq_ready), 1);
    chk("a_quota_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    le = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_data_sym", 32'(sym_out), 32'(va[i]));
    end
    tick();
    chk("a_tail1_sym", 32'(sym_out), 0);
    chk("a_tail1_frame_done", 32'(frame_done), 0);
    chk("a_tail1_seq_ready", 32'(seq_ready), 1);
    tick();
    le = 1'b0;
    chk("a_tail2_sym", 32'(sym_out), 0);
    chk("a_done_frame_done", 32'(frame_done), 1);
    chk("a_done_seq_ready", 32'(seq_ready), 0);
    chk("a_done_underrun", 32'(underrun), 0);
    tick();
    chk("a_idle_frame_done", 32'(frame_done), 0);
    chk("a_idle_busy", 32'(busy), 0);

    // B: fill to capacity, pop against a full FIFO, then run dry.
    sel = 1;
    start = 1'b1; tick(); start = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_sym = vb[acc];
      if (in_ready) acc++;
      tick();
    end
    chk("b_accepted", 32'(acc), 8);
    chk("b_full_in_ready", 32'(in_ready), 0);
    chk("b_full_seq_ready", 32'(seq_ready), 1);
    in_sym = vb[8];
    le = 1'b1;
    chk("b_full_le_in_ready", 32'(in_ready), 0);
    tick();
    le = 1'b0;
    chk("b_pop_sym", 32'(sym_out), 32'(vb[0]));
    chk("b_after_pop_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("b_refull_in_ready", 32'(in_ready), 0);
    le = 1'b1;
    for (int i = 1; i < 9; i++) begin
      tick();
      chk("b_drain_sym", 32'(sym_out), 32'(vb[i]));
    end
    chk("b_drain_underrun", 32'(underrun), 0);
    tick();
    chk("b_erasure_sym", 32'(sym_out), 0);
    chk("b_erasure_underrun", 32'(underrun), 1);
    tick(); tick(); tick(); tick();
    le = 1'b0;
    chk("b_done_frame_done", 32'(frame_done), 1);
    chk("b_done_underrun", 32'(underrun), 1);
    tick();
    chk("b_idle_frame_done", 32'(frame_done), 0);
    chk("b_idle_underrun", 32'(underrun), 1);
    chk("b_idle_busy", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("b_restart_underrun", 32'(underrun), 0);
    chk("b_restart_busy", 32'(busy), 1);

    // C: frame shorter than the preload level arms on the last data symbol.
    sel = 2;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    in_sym = 3'd6; tick();
    chk("c_1push_seq_ready", 32'(seq_ready), 0);
    in_sym = 3'd3; tick();
    chk("c_2push_seq_ready", 32'(seq_ready), 1);
    chk("c_quota_in_ready", 32'(in_ready), 0);
    tick();
    chk("c_third_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    le = 1'b1;
    tick(); chk("c_sym0", 32'(sym_out), 6);
    tick(); chk("c_sym1", 32'(sym_out), 3);
    tick(); chk("c_tail_sym", 32'(sym_out), 0);
    tick();
    le = 1'b0;
    chk("c_frame_done", 32'(frame_done), 1);
    chk("c_underrun", 32'(underrun), 0);
    tick();

    // A: reset mid-run with 3 symbols buffered, then refill with fresh data.
    sel = 0;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sym = va[i];
      tick();
    end
    in_valid = 1'b0;
    le = 1'b1; tick(); le = 1'b0;
    chk("ar_first_sym", 32'(sym_out), 5);
    chk("ar_run_seq_ready", 32'(seq_ready), 1);
    reset = 1'b1;
    #1;
    chk_all_zero("ar_async");
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sym = vn[i];
      tick();
    end
    in_valid = 1'b0;
    chk("ar_refill_seq_ready", 32'(seq_ready), 1);
    le = 1'b1;
    tick(); chk("ar_new_sym0", 32'(sym_out), 2);
    tick(); chk("ar_new_sym1", 32'(sym_out), 4);
    le = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
